// File: rtl/mult5_seq_arbiter.sv
// Shift-add multiplier shared between two requesters by a round-robin arbiter.
// The block takes one operand pair, multiplies in WIDTH cycles, then holds the tagged product.
module mult5_seq_arbiter #(
    parameter int WIDTH = 5,
    parameter int CNT_W = 3
) (
    input  logic               wb_clk_i,
    input  logic               rst_n,
    input  logic               req0_valid,
    input  logic [WIDTH-1:0]   req0_a,
    input  logic [WIDTH-1:0]   req0_b,
    output logic               req0_ready,
    input  logic               req1_valid,
    input  logic [WIDTH-1:0]   req1_a,
    input  logic [WIDTH-1:0]   req1_b,
    output logic               req1_ready,
    output logic               res_valid,
    output logic [2*WIDTH-1:0] res_product,
    output logic               res_id,
    input  logic               res_ready,
    output logic               busy
);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

    state_t               state;
    logic                 rr_ptr;
    logic [2*WIDTH-1:0]   acc;
    logic [WIDTH-1:0]     a_reg;
    logic [WIDTH-1:0]     b_reg;
    logic [CNT_W-1:0]     cnt;

    logic                 grant;
    logic [2*WIDTH-1:0]   addend;
    logic [2*WIDTH-1:0]   acc_next;

    // The pointer only breaks ties; a lone requester is served regardless of it.
    // Readies are gated by rst_n so nothing is offered while the block is held in reset.
    always_comb begin
        grant      = (req0_valid && req1_valid) ? rr_ptr : req1_valid;
        req0_ready = rst_n && (state == IDLE) && req0_valid && !grant;
        req1_ready = rst_n && (state == IDLE) && req1_valid && grant;
        addend     = {{WIDTH{1'b0}}, a_reg} << cnt;
        acc_next   = b_reg[cnt] ? (acc + addend) : acc;
    end

    always_ff @(posedge wb_clk_i or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            rr_ptr      <= 1'b0;
            acc         <= '0;
            a_reg       <= '0;
            b_reg       <= '0;
            cnt         <= '0;
            res_valid   <= 1'b0;
            res_product <= '0;
            res_id      <= 1'b0;
            busy        <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (req0_ready || req1_ready) begin
                        a_reg  <= grant ? req1_a : req0_a;
                        b_reg  <= grant ? req1_b : req0_b;
                        res_id <= grant;
                        rr_ptr <= ~grant;
                        acc    <= '0;
                        cnt    <= '0;
                        busy   <= 1'b1;
                        state  <= RUN;
                    end
                end
                // Fixed WIDTH iterations; zero operands still take the full count.
                RUN: begin
                    acc <= acc_next;
                    cnt <= cnt + 1'b1;
                    if (cnt == LAST_CNT) begin
                        res_product <= acc_next;
                        res_valid   <= 1'b1;
                        state       <= DONE;
                    end
                end
                DONE: begin
                    if (res_ready) begin
                        res_valid <= 1'b0;
                        busy      <= 1'b0;
                        state     <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mult5_seq_arbiter.sv
// Directed bench for mult5_seq_arbiter: latency, products, round-robin order, backpressure and reset.
module tb_mult5_seq_arbiter;

    logic       wb_clk_i = 1'b0;
    logic       rst_n;
    logic       req0_valid, req1_valid;
    logic [4:0] req0_a, req0_b, req1_a, req1_b;
    logic       req0_ready, req1_ready;
    logic       res_valid;
    logic [9:0] res_product;
    logic       res_id;
    logic       res_ready;
    logic       busy;

    int total = 0;
    int bad   = 0;

    mult5_seq_arbiter #(.WIDTH(5), .CNT_W(3)) dut (
        .wb_clk_i    (wb_clk_i),
        .rst_n       (rst_n),
        .req0_valid  (req0_valid),
        .req0_a      (req0_a),
        .req0_b      (req0_b),
        .req0_ready  (req0_ready),
        .req1_valid  (req1_valid),
        .req1_a      (req1_a),
        .req1_b      (req1_b),
        .req1_ready  (req1_ready),
        .res_valid   (res_valid),
        .res_product (res_product),
        .res_id      (res_id),
        .res_ready   (res_ready),
        .busy        (busy)
    );

    always #5 wb_clk_i = ~wb_clk_i;

    // Counts negedges after the accept edge until res_valid; 20 means it never came.
    task automatic wait_res(output int lat);
        lat = 1;
        while (!res_valid && lat < 20) begin
            @(negedge wb_clk_i);
            lat++;
        end
    endtask

    task automatic handshake();
        res_ready = 1'b1;
        @(posedge wb_clk_i);
        @(negedge wb_clk_i);
        res_ready = 1'b0;
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        req0_valid = 1'b1; req0_a = 5'd3; req0_b = 5'd3;
        req1_valid = 1'b0; req1_a = 5'd0; req1_b = 5'd0;
        res_ready = 1'b0;
        repeat (3) @(negedge wb_clk_i);
        total++;
        if (req0_ready !== 1'b0 || req1_ready !== 1'b0 || res_valid !== 1'b0 || busy !== 1'b0)
            begin bad++; $display("[TB] FAIL reset_hold got r0=%b r1=%b v=%b busy=%b want all 0", req0_ready, req1_ready, res_valid, busy); end
        req0_valid = 1'b0;
        rst_n = 1'b1;
        @(negedge wb_clk_i);
        total++;
        if (busy !== 1'b0 || req0_ready !== 1'b0 || req1_ready !== 1'b0 || res_valid !== 1'b0 ||
            res_product !== 10'd0 || res_id !== 1'b0)
            begin bad++; $display("[TB] FAIL reset_release got busy=%b r0=%b r1=%b v=%b p=%0d id=%b want all 0", busy, req0_ready, req1_ready, res_valid, res_product, res_id); end
    endtask

    task automatic test_single();
        int lat;
        @(negedge wb_clk_i);
        req0_valid = 1'b1; req0_a = 5'd31; req0_b = 5'd31;
        #1;
        total++;
        if (req0_ready !== 1'b1 || req1_ready !== 1'b0)
            begin bad++; $display("[TB] FAIL single_ready got r0=%b r1=%b want r0=1 r1=0", req0_ready, req1_ready); end
        @(posedge wb_clk_i);
        @(negedge wb_clk_i);
        req0_valid = 1'b0;
        total++;
        if (busy !== 1'b1) begin bad++; $display("[TB] FAIL single_busy got %b want 1", busy); end
        wait_res(lat);
        total++;
        if (lat != 6) begin bad++; $display("[TB] FAIL single_latency got %0d want 6", lat); end
        total++;
        if (res_product !== 10'd961) begin bad++; $display("[TB] FAIL single_product got %0d want 961", res_product); end
        total++;
        if (res_id !== 1'b0) begin bad++; $display("[TB] FAIL single_id got %b want 0", res_id); end
        handshake();
        total++;
        if (res_valid !== 1'b0 || busy !== 1'b0)
            begin bad++; $display("[TB] FAIL single_release got v=%b busy=%b want 0 0", res_valid, busy); end
    endtask

    task automatic test_edge_operands();
        logic [4:0] va[3] = '{5'd0, 5'd1, 5'd16};
        logic [4:0] vb[3] = '{5'd17, 5'd1, 5'd2};
        logic [9:0] vp[3] = '{10'd0, 10'd1, 10'd32};
        int lat;
        for (int i = 0; i < 3; i++) begin
            @(negedge wb_clk_i);
            req1_valid = 1'b1; req1_a = va[i]; req1_b = vb[i];
            #1;
            total++;
            if (req1_ready !== 1'b1) begin bad++; $display("[TB] FAIL edge_ready[%0d] got %b want 1", i, req1_ready); end
            @(posedge wb_clk_i);
            @(negedge wb_clk_i);
            req1_valid = 1'b0;
            wait_res(lat);
            total++;
            if (lat != 6 || res_product !== vp[i] || res_id !== 1'b1)
                begin bad++; $display("[TB] FAIL edge_result[%0d] got lat=%0d p=%0d id=%b want lat=6 p=%0d id=1", i, lat, res_product, res_id, vp[i]); end
            handshake();
        end
    endtask

    task automatic test_contention();
        logic [4:0] a0[2] = '{5'd3, 5'd10};
        logic [4:0] b0[2] = '{5'd4, 5'd11};
        logic [4:0] a1[2] = '{5'd5, 5'd31};
        logic [4:0] b1[2] = '{5'd6, 5'd2};
        logic       exp_id[4]   = '{1'b0, 1'b1, 1'b0, 1'b1};
        logic [9:0] exp_prod[4] = '{10'd12, 10'd30, 10'd110, 10'd62};
        int i0 = 0, i1 = 0, grants = 0, results = 0, viol = 0, cyc = 0;
        logic acc0, acc1;
        @(negedge wb_clk_i);
        res_ready = 1'b1;
        req0_valid = 1'b1; req0_a = a0[0]; req0_b = b0[0];
        req1_valid = 1'b1; req1_a = a1[0]; req1_b = b1[0];
        #1;
        while (results < 4 && cyc < 200) begin
            if ((req0_ready && req1_ready) || (busy && (req0_ready || req1_ready))) viol++;
            if (res_valid) begin
                total++;
                if (res_product !== exp_prod[results] || res_id !== exp_id[results])
                    begin bad++; $display("[TB] FAIL contention_result[%0d] got p=%0d id=%b want p=%0d id=%b", results, res_product, res_id, exp_prod[results], exp_id[results]); end
                results++;
            end
            acc0 = req0_ready;
            acc1 = req1_ready;
            if ((acc0 || acc1) && grants < 4) begin
                total++;
                if (acc1 !== exp_id[grants])
                    begin bad++; $display("[TB] FAIL contention_grant[%0d] got %b want %b", grants, acc1, exp_id[grants]); end
                grants++;
            end
            @(posedge wb_clk_i);
            @(negedge wb_clk_i);
            cyc++;
            if (acc0) begin
                i0++;
                if (i0 < 2) begin req0_a = a0[i0]; req0_b = b0[i0]; end else req0_valid = 1'b0;
            end
            if (acc1) begin
                i1++;
                if (i1 < 2) begin req1_a = a1[i1]; req1_b = b1[i1]; end else req1_valid = 1'b0;
            end
            #1;
        end
        res_ready = 1'b0;
        total++;
        if (results != 4 || grants != 4)
            begin bad++; $display("[TB] FAIL contention_count got results=%0d grants=%0d want 4 4", results, grants); end
        total++;
        if (viol != 0) begin bad++; $display("[TB] FAIL contention_ready_rule got %0d violations want 0", viol); end
    endtask

    task automatic test_backpressure();
        int lat;
        @(negedge wb_clk_i);
        req0_valid = 1'b1; req0_a = 5'd13; req0_b = 5'd7;
        req1_valid = 1'b1; req1_a = 5'd2;  req1_b = 5'd3;
        #1;
        total++;
        if (req0_ready !== 1'b1 || req1_ready !== 1'b0)
            begin bad++; $display("[TB] FAIL bp_grant got r0=%b r1=%b want 1 0", req0_ready, req1_ready); end
        @(posedge wb_clk_i);
        @(negedge wb_clk_i);
        req0_valid = 1'b0;
        wait_res(lat);
        total++;
        if (lat != 6) begin bad++; $display("[TB] FAIL bp_latency got %0d want 6", lat); end
        for (int i = 0; i < 10; i++) begin
            @(negedge wb_clk_i);
            total++;
            if (res_valid !== 1'b1 || res_product !== 10'd91 || res_id !== 1'b0 ||
                req0_ready !== 1'b0 || req1_ready !== 1'b0)
                begin bad++; $display("[TB] FAIL bp_hold[%0d] got v=%b p=%0d id=%b r0=%b r1=%b want 1 91 0 0 0", i, res_valid, res_product, res_id, req0_ready, req1_ready); end
        end
        handshake();
        total++;
        if (busy !== 1'b0 || res_valid !== 1'b0 || req1_ready !== 1'b1)
            begin bad++; $display("[TB] FAIL bp_release got busy=%b v=%b r1=%b want 0 0 1", busy, res_valid, req1_ready); end
        @(posedge wb_clk_i);
        @(negedge wb_clk_i);
        req1_valid = 1'b0;
        wait_res(lat);
        total++;
        if (lat != 6 || res_product !== 10'd6 || res_id !== 1'b1)
            begin bad++; $display("[TB] FAIL bp_next got lat=%0d p=%0d id=%b want 6 6 1", lat, res_product, res_id); end
        handshake();
    endtask

    task automatic test_reset_mid();
        int lat;
        @(negedge wb_clk_i);
        req0_valid = 1'b1; req0_a = 5'd7; req0_b = 5'd9;
        #1;
        total++;
        if (req0_ready !== 1'b1) begin bad++; $display("[TB] FAIL rmid_accept got %b want 1", req0_ready); end
        @(posedge wb_clk_i);
        @(negedge wb_clk_i);
        req0_valid = 1'b0;
        repeat (2) @(negedge wb_clk_i);
        #2 rst_n = 1'b0;
        #1;
        total++;
        if (busy !== 1'b0 || res_valid !== 1'b0 || res_product !== 10'd0 || res_id !== 1'b0 ||
            req0_ready !== 1'b0 || req1_ready !== 1'b0)
            begin bad++; $display("[TB] FAIL rmid_async got busy=%b v=%b p=%0d id=%b r0=%b r1=%b want all 0", busy, res_valid, res_product, res_id, req0_ready, req1_ready); end
        req0_valid = 1'b1; req0_a = 5'd7; req0_b = 5'd9;
        req1_valid = 1'b1; req1_a = 5'd3; req1_b = 5'd5;
        repeat (2) @(negedge wb_clk_i);
        total++;
        if (req0_ready !== 1'b0 || req1_ready !== 1'b0 || res_valid !== 1'b0)
            begin bad++; $display("[TB] FAIL rmid_hold got r0=%b r1=%b v=%b want 0 0 0", req0_ready, req1_ready, res_valid); end
        rst_n = 1'b1;
        #1;
        total++;
        if (req0_ready !== 1'b1 || req1_ready !== 1'b0)
            begin bad++; $display("[TB] FAIL rmid_rrptr got r0=%b r1=%b want 1 0", req0_ready, req1_ready); end
        @(posedge wb_clk_i);
        @(negedge wb_clk_i);
        req0_valid = 1'b0;
        wait_res(lat);
        total++;
        if (lat != 6 || res_product !== 10'd63 || res_id !== 1'b0)
            begin bad++; $display("[TB] FAIL rmid_first got lat=%0d p=%0d id=%b want 6 63 0", lat, res_product, res_id); end
        handshake();
        total++;
        if (req1_ready !== 1'b1) begin bad++; $display("[TB] FAIL rmid_second_ready got %b want 1", req1_ready); end
        @(posedge wb_clk_i);
        @(negedge wb_clk_i);
        req1_valid = 1'b0;
        wait_res(lat);
        total++;
        if (lat != 6 || res_product !== 10'd15 || res_id !== 1'b1)
            begin bad++; $display("[TB] FAIL rmid_second got lat=%0d p=%0d id=%b want 6 15 1", lat, res_product, res_id); end
        handshake();
    endtask

    initial begin
        test_reset();
        test_single();
        test_edge_operands();
        test_contention();
        test_backpressure();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
